cdb_result_queue: RTL and testbench

- Producer-side (transmitter) endpoint of the valid/yumi handshake into cdb_scheduler.
- Sits between a functional unit (adder, multiply, divide) and the CDB arbiter.
- Buffers completed results so a FU whose result loses CDB arbitration can keep accepting work, instead of stalling through its ready output.
- Presents the oldest buffered result to the arbiter and retires it on yumi_in.
- Discards all contents on mispredict flush.

---
 rtl/cdb_result_queue.sv | 77 +++++++
 tb/tb_cdb_result_queue.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cdb_result_queue.sv
// rtl/cdb_result_queue.sv - FU result buffer feeding the CDB arbiter over a valid/yumi handshake
module cdb_result_queue #(
    parameter int DEPTH = 4,
    parameter int PKT_W = 37,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [PKT_W-1:0] din,
    output logic             ready,
    output logic             valid_out,
    output logic [PKT_W-1:0] out,
    input  logic             yumi_in,
    output logic [CNT_W-1:0] count,
    output logic             err
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PKT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             push;
    logic             pop;
    logic             violation;

    // ready depends only on registered occupancy, so a full queue rejects
    // din even when the head is consumed in the same cycle.
    assign ready     = (count != CNT_W'(DEPTH));
    assign valid_out = (count != '0);
    assign out       = valid_out ? mem[rptr] : '0;

    assign push      = valid_in & ready & ~flush;
    assign pop       = yumi_in & valid_out & ~flush;
    assign violation = (valid_in & ~ready) | (yumi_in & ~valid_out);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (violation) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cdb_result_queue.sv
// tb/tb_cdb_result_queue.sv - directed table-driven bench for cdb_result_queue
module tb_cdb_result_queue;
    localparam int DEPTH = 4;
    localparam int PKT_W = 37;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             valid_in;
    logic [PKT_W-1:0] din;
    logic             ready;
    logic             valid_out;
    logic [PKT_W-1:0] out;
    logic             yumi_in;
    logic [CNT_W-1:0] count;
    logic             err;

    int passed;
    int total;

    typedef struct {
        logic             vi;
        logic [PKT_W-1:0] d;
        logic             yu;
        logic             fl;
        logic             rdy;
        logic             vo;
        logic [PKT_W-1:0] o;
        logic [CNT_W-1:0] c;
        logic             e;
    } vec_t;

    vec_t vecs[$];

    cdb_result_queue #(.DEPTH(DEPTH), .PKT_W(PKT_W), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .valid_in(valid_in),
        .din(din),
        .ready(ready),
        .valid_out(valid_out),
        .out(out),
        .yumi_in(yumi_in),
        .count(count),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic rdy, input logic vo,
                             input logic [PKT_W-1:0] o, input logic [CNT_W-1:0] c, input logic e);
        check({tag, ".ready"}, 64'(ready), 64'(rdy));
        check({tag, ".valid_out"}, 64'(valid_out), 64'(vo));
        check({tag, ".out"}, 64'(out), 64'(o));
        check({tag, ".count"}, 64'(count), 64'(c));
        check({tag, ".err"}, 64'(err), 64'(e));
    endtask

    // Drive inputs, take one rising edge, release inputs 1 time unit later.
    task automatic step(input logic vi, input logic [PKT_W-1:0] d, input logic yu, input logic fl);
        valid_in = vi;
        din      = d;
        yumi_in  = yu;
        flush    = fl;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        din      = '0;
        yumi_in  = 1'b0;
        flush    = 1'b0;
    endtask

    function automatic vec_t mk(input logic vi, input logic [PKT_W-1:0] d, input logic yu,
                                input logic fl, input logic rdy, input logic vo,
                                input logic [PKT_W-1:0] o, input logic [CNT_W-1:0] c,
                                input logic e);
        vec_t v;
        v.vi = vi; v.d = d; v.yu = yu; v.fl = fl;
        v.rdy = rdy; v.vo = vo; v.o = o; v.c = c; v.e = e;
        return v;
    endfunction

    initial begin
        passed   = 0;
        total    = 0;
        reset    = 1'b0;
        flush    = 1'b0;
        valid_in = 1'b0;
        din      = '0;
        yumi_in  = 1'b0;

        //           vi  din    yu  fl   rdy vo  out    cnt e
        vecs.push_back(mk(1, 'h0A, 0, 0,  1, 1, 'h0A, 1, 0));
        vecs.push_back(mk(1, 'h0B, 0, 0,  1, 1, 'h0A, 2, 0));
        vecs.push_back(mk(1, 'h0C, 0, 0,  1, 1, 'h0A, 3, 0));
        vecs.push_back(mk(1, 'h0D, 0, 0,  0, 1, 'h0A, 4, 0));
        vecs.push_back(mk(1, 'h0E, 1, 0,  0, 1, 'h0A, 4, 1)); // full: push refused even with yumi? no, yumi pops
        vecs.delete(vecs.size() - 1);
        vecs.push_back(mk(1, 'h0E, 0, 0,  0, 1, 'h0A, 4, 1));
        vecs.push_back(mk(0, 'h00, 1, 0,  1, 1, 'h0B, 3, 1));
        vecs.push_back(mk(0, 'h00, 1, 0,  1, 1, 'h0C, 2, 1));
        vecs.push_back(mk(0, 'h00, 1, 0,  1, 1, 'h0D, 1, 1));
        vecs.push_back(mk(0, 'h00, 1, 0,  1, 0, 'h00, 0, 1));
        vecs.push_back(mk(1, 'h11, 0, 0,  1, 1, 'h11, 1, 1));
        vecs.push_back(mk(1, 'h22, 1, 0,  1, 1, 'h22, 1, 1));
        vecs.push_back(mk(0, 'h00, 1, 0,  1, 0, 'h00, 0, 1));
        vecs.push_back(mk(1, 'h30, 0, 0,  1, 1, 'h30, 1, 1));
        vecs.push_back(mk(1, 'h31, 0, 0,  1, 1, 'h30, 2, 1));
        vecs.push_back(mk(1, 'h32, 0, 0,  1, 1, 'h30, 3, 1));
        vecs.push_back(mk(1, 'h33, 0, 1,  1, 0, 'h00, 0, 1));
        vecs.push_back(mk(1, 'h44, 0, 0,  1, 1, 'h44, 1, 1));
        vecs.push_back(mk(0, 'h00, 1, 0,  1, 0, 'h00, 0, 1));

        repeat (3) @(posedge clk);
        #1;
        check_all("in_reset", 1'b1, 1'b0, '0, '0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("idle", 1'b1, 1'b0, '0, '0, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].vi, vecs[i].d, vecs[i].yu, vecs[i].fl);
            check_all($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].vo, vecs[i].o, vecs[i].c, vecs[i].e);
        end

        // Wrap-around: pointers cycle through the buffer several times.
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, PKT_W'(k), 1'b0, 1'b0);
            check($sformatf("wrap%0d.out", k), 64'(out), 64'(k));
            step(1'b0, '0, 1'b1, 1'b0);
        end
        check("wrap.count", 64'(count), 64'd0);
        check("wrap.valid_out", 64'(valid_out), 64'd0);

        // Full queue with simultaneous yumi: head retires, din is still refused.
        for (int k = 0; k < DEPTH; k++) begin
            step(1'b1, PKT_W'('h50 + k), 1'b0, 1'b0);
        end
        step(1'b1, 'h5F, 1'b1, 1'b0);
        check("fullyumi.count", 64'(count), 64'(DEPTH - 1));
        check("fullyumi.out", 64'(out), 64'h51);
        for (int k = 1; k < DEPTH; k++) begin
            check($sformatf("drain%0d.out", k), 64'(out), 64'('h50 + k));
            step(1'b0, '0, 1'b1, 1'b0);
        end
        check("drain.count", 64'(count), 64'd0);

        // Asynchronous reset mid-cycle with two entries held.
        step(1'b1, 'h61, 1'b0, 1'b0);
        step(1'b1, 'h62, 1'b0, 1'b0);
        check("prereset.count", 64'(count), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_reset", 1'b1, 1'b0, '0, '0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Spurious consume on an empty queue sets err without moving state.
        step(1'b0, '0, 1'b1, 1'b0);
        check_all("spurious", 1'b1, 1'b0, '0, '0, 1'b1);
        step(1'b1, 'h77, 1'b0, 1'b0);
        check_all("after_spurious", 1'b1, 1'b1, 'h77, 1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
